// File: rtl/sub_div_seq.sv
// Multi-cycle restoring divider: one WIDTH-bit subtractor reused once per quotient bit.
// Optional two's-complement mode compiled in with `define SUB_DIV_SIGNED_EN.
module sub_div_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             DivByZero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             dbz;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] a_load;
  logic [WIDTH-1:0] b_load;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

`ifdef SUB_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Iterate on magnitudes; signs are reapplied when results are written.
  always_comb begin
    a_load = A[WIDTH-1] ? (~A + 1'b1) : A;
    b_load = B[WIDTH-1] ? (~B + 1'b1) : B;
    q_res  = neg_q ? (~dvd + 1'b1) : dvd;
    r_res  = neg_r ? (~prem + 1'b1) : prem;
  end
`else
  always_comb begin
    a_load = A;
    b_load = B;
    q_res  = dvd;
    r_res  = prem;
  end
`endif

  // dvd doubles as the quotient shift register: dividend bits leave at the MSB,
  // quotient bits enter at the LSB.
  always_comb begin
    shifted = {prem, dvd[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    borrow  = diff[WIDTH+1];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quot      <= '0;
      Rem       <= '0;
      DivByZero <= 1'b0;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      dbz       <= 1'b0;
`ifdef SUB_DIV_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (B != '0) begin
              dvd   <= a_load;
              dvs   <= b_load;
              prem  <= '0;
              cnt   <= CNT_W'(WIDTH - 1);
              dbz   <= 1'b0;
              Busy  <= 1'b1;
              state <= S_CALC;
`ifdef SUB_DIV_SIGNED_EN
              neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
              neg_r <= A[WIDTH-1];
`endif
            end else begin
              // Raw dividend is kept so the remainder reports A unchanged.
              dvd   <= A;
              dbz   <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_CALC: begin
          dvd  <= {dvd[WIDTH-2:0], ~borrow};
          prem <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          if (cnt == '0) begin
            Busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIN: begin
          Done      <= 1'b1;
          DivByZero <= dbz;
          if (dbz) begin
            Quot <= '1;
            Rem  <= dvd;
          end else begin
            Quot <= q_res;
            Rem  <= r_res;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_div_seq.sv
// Scoreboard bench for sub_div_seq: stimulus pushes expected results, a monitor
// pops and checks them on every Done pulse (value, latency, busy cycles).
module tb_sub_div_seq;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Busy;
  logic        Done;
  logic [15:0] Quot;
  logic [15:0] Rem;
  logic        DivByZero;

  sub_div_seq #(.WIDTH(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Quot(Quot), .Rem(Rem), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          due;
    int          busy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   busy_cnt = 0;

  always @(posedge Clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge Clk) begin
    if (Rst) busy_cnt = 0;
    else if (Busy === 1'b1) busy_cnt = busy_cnt + 1;
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors = vectors + 1;
        miscompares = miscompares + 1;
        $display("FAIL unexpected_done: got Done=1 with Quot=%0h Rem=%0h, expected no Done (cycle %0d)",
                 Quot, Rem, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quot", 32'(Quot), 32'(e.q));
        chk("rem", 32'(Rem), 32'(e.r));
        chk("div_by_zero", 32'(DivByZero), 32'(e.dbz));
        chk("done_cycle", 32'(cyc), 32'(e.due));
        chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
      end
      busy_cnt = 0;
    end
  end

  function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r, input logic dbz, input int due);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.due = due;
    e.busy = dbz ? 0 : 16;
    return e;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r, input logic dbz);
    @(negedge Clk);
    A = a; B = b; Start = 1'b1;
    sb.push_back(mk(q, r, dbz, cyc + 1 + (dbz ? 1 : 17)));
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge Clk);
      n++;
    end
    @(negedge Clk);
    vectors = vectors + 1;
    if (sb.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_quot", 32'(Quot), 32'd0);
    chk("reset_rem", 32'(Rem), 32'd0);
    chk("reset_dbz", 32'(DivByZero), 32'd0);
    Rst = 1'b0;

    issue(16'd64, 16'd8, 16'd8, 16'd0, 1'b0);          drain(40);
    issue(16'd65, 16'd8, 16'd8, 16'd1, 1'b0);          drain(40);
    issue(16'd256, 16'd257, 16'd0, 16'd256, 1'b0);     drain(40);
    issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);     drain(40);
    issue(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0);     drain(40);
    issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);     drain(40);
`ifndef SUB_DIV_SIGNED_EN
    issue(16'd7, 16'd9, 16'd0, 16'd7, 1'b0);           drain(40);
    issue(16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0); drain(40);
`else
    issue(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0);  drain(40);
    issue(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0);  drain(40);
    issue(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0);     drain(40);
`endif
    issue(16'd1, 16'd0, 16'hFFFF, 16'd1, 1'b1);        drain(10);

    // Abort mid-operation: no Done may follow, everything clears.
    @(negedge Clk);
    A = 16'd64; B = 16'd8; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_quot", 32'(Quot), 32'd0);
    chk("abort_rem", 32'(Rem), 32'd0);
    chk("abort_dbz", 32'(DivByZero), 32'd0);
    repeat (20) @(negedge Clk);
    chk("abort_busy_later", 32'(Busy), 32'd0);

    // Start held 40 cycles; operands change mid-CALC and only affect later captures.
    @(negedge Clk);
    A = 16'd100; B = 16'd7; Start = 1'b1;
    sb.push_back(mk(16'd14, 16'd2, 1'b0, cyc + 18));
    sb.push_back(mk(16'd3, 16'd0, 1'b0, cyc + 36));
    sb.push_back(mk(16'd3, 16'd0, 1'b0, cyc + 54));
    repeat (8) @(negedge Clk);
    A = 16'd9; B = 16'd3;
    repeat (32) @(negedge Clk);
    Start = 1'b0;
    drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
